// File: rtl/midori_share_pkg.sv
// Shared types and constants for the Midori64 three-share output recombiner.
package midori_share_pkg;

  localparam int NIB_W   = 4;
  localparam int NIBBLES = 16;
  localparam int DATA_W  = NIB_W * NIBBLES;

  typedef enum logic {
    COLLECT,
    HOLD
  } state_t;

  // Index of the random nibble expected on beat idx: 0123, 1032, 2301, 3210.
  function automatic logic [1:0] pattern_src(input logic [3:0] idx);
    return idx[1:0] ^ idx[3:2];
  endfunction

endpackage

// File: rtl/midori_nibble_deser.sv
// Nibble-in, 64-bit-out shift register; the first nibble shifted in ends up in the MSBs.
module midori_nibble_deser
  import midori_share_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic [NIB_W-1:0]  nib,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (shift_en) begin
      data <= {data[DATA_W-NIB_W-1:0], nib};
    end
  end

endmodule

// File: rtl/midori_share_decoder_r1r2r3r4.sv
// Deserialises three nibble-serial output shares, recombines them and checks that
// shares 0 and 1 follow the r1r2r3r4 row-permuted replication pattern.
module midori_share_decoder_r1r2r3r4
  import midori_share_pkg::*;
#(
  parameter bit CHECK_PATTERN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_nib0,
  input  logic [3:0]  in_nib1,
  input  logic [3:0]  in_nib2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pt,
  output logic [63:0] out_share0,
  output logic [63:0] out_share1,
  output logic        out_pattern_ok
);

  state_t                     state, next_state;
  logic [3:0]                 count;
  logic [3:0][NIB_W-1:0]      r0_q, r1_q;
  logic                       mismatch, pattern_ok_q;
  logic                       xfer, last_beat, hold_exit, beat_bad;
  logic [1:0]                 src;
  logic [DATA_W-1:0]          share0, share1, share2;

  assign in_ready  = (state == COLLECT) && !rst;
  assign xfer      = in_valid && in_ready;
  assign last_beat = (count == 4'(NIBBLES - 1));
  assign hold_exit = (state == HOLD) && out_ready;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= next_state;
  end

  // NOTE: next_state gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      COLLECT: if (xfer && last_beat) next_state = HOLD;
      HOLD:    if (out_ready)         next_state = COLLECT;
      default: next_state = COLLECT;
    endcase
  end

  // 4-bit counter wraps 15 -> 0 on the same edge that enters HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (xfer) count <= count + 4'd1;
  end

  always_comb begin
    src      = pattern_src(count);
    beat_bad = (count[3:2] != 2'b00) &&
               ((in_nib0 != r0_q[src]) || (in_nib1 != r1_q[src]));
  end

  // NOTE: the r latches are a tiny register file, reset so the first compare is deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_q     <= '0;
      r1_q     <= '0;
      mismatch <= 1'b0;
    end else if (hold_exit) begin
      r0_q     <= '0;
      r1_q     <= '0;
      mismatch <= 1'b0;
    end else if (xfer) begin
      if (count[3:2] == 2'b00) begin
        r0_q[count[1:0]] <= in_nib0;
        r1_q[count[1:0]] <= in_nib1;
      end else if (beat_bad) begin
        mismatch <= 1'b1;
      end
    end
  end

  // The last beat's own compare is folded in as the verdict is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    pattern_ok_q <= 1'b1;
    else if (xfer && last_beat) pattern_ok_q <= !(mismatch || beat_bad);
  end

  midori_nibble_deser u_deser0 (.clk(clk), .rst(rst), .shift_en(xfer), .nib(in_nib0), .data(share0));
  midori_nibble_deser u_deser1 (.clk(clk), .rst(rst), .shift_en(xfer), .nib(in_nib1), .data(share1));
  midori_nibble_deser u_deser2 (.clk(clk), .rst(rst), .shift_en(xfer), .nib(in_nib2), .data(share2));

  assign out_valid      = (state == HOLD);
  assign out_pt         = share0 ^ share1 ^ share2;
  assign out_share0     = share0;
  assign out_share1     = share1;
  assign out_pattern_ok = CHECK_PATTERN ? pattern_ok_q : 1'b1;

endmodule
